// File: rtl/siso_shift_ctrl.sv
// Serial-in/serial-out shift sequencer: accepts a parallel word on start/ready, shifts it out
// one bit per clock framed by sout_valid, then pulses done. Optional parity bit: SISO_SHIFT_CTRL_PARITY_EN.
module siso_shift_ctrl #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   input  logic             abort,
   output logic             ready,
   output logic             busy,
   output logic             sout,
   output logic             sout_valid,
   output logic             done,
   output logic             dbg_state
);

`ifdef SISO_SHIFT_CTRL_PARITY_EN
   localparam int FLEN = WIDTH + 1;
`else
   localparam int FLEN = WIDTH;
`endif
   localparam int CW = $clog2(WIDTH + 2);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] sr, sr_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             sout_n, valid_n, done_n;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
   logic             par, par_n;
`endif

   // Bit that goes on the line next, and the register after that bit is consumed.
   function automatic logic head(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   // Handshake: a start sampled high on a rising edge while ready=1 is accepted on that edge
   // and data_in is captured then; while ready=0 start is ignored and nothing is queued.
   always_comb begin
      state_n = state;
      sr_n    = sr;
      cnt_n   = cnt;
      sout_n  = 1'b0;
      valid_n = 1'b0;
      done_n  = 1'b0;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
      par_n   = par;
`endif
      if (state == IDLE) begin
         if (start) begin
            sr_n    = advance(data_in);
            sout_n  = head(data_in);
            valid_n = 1'b1;
            cnt_n   = CW'(1);
            state_n = SHIFT;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
            par_n   = ^data_in;
`endif
         end
      end else begin
         if (abort) begin
            // Abort outranks completion, so done cannot follow a cancelled frame.
            state_n = IDLE;
            sr_n    = '0;
            cnt_n   = '0;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
            par_n   = 1'b0;
`endif
         end else if (cnt == CW'(FLEN)) begin
            state_n = IDLE;
            sr_n    = '0;
            cnt_n   = '0;
            done_n  = 1'b1;
         end else begin
            valid_n = 1'b1;
            cnt_n   = cnt + CW'(1);
`ifdef SISO_SHIFT_CTRL_PARITY_EN
            if (cnt < CW'(WIDTH)) begin
               sout_n = head(sr);
               sr_n   = advance(sr);
            end else begin
               sout_n = par;
            end
`else
            sout_n = head(sr);
            sr_n   = advance(sr);
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         sr         <= '0;
         cnt        <= '0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         done       <= 1'b0;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         sr         <= sr_n;
         cnt        <= cnt_n;
         sout       <= sout_n;
         sout_valid <= valid_n;
         done       <= done_n;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
         par        <= par_n;
`endif
      end
   end

   assign ready     = (state == IDLE);
   assign busy      = (state == SHIFT);
   assign dbg_state = state;

endmodule
